// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller slice.
// Mux select encodings match the datapath wiring of the operand and subtractor muxes.
package gcd_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic SEL_DIN = 1'b0;
  localparam logic SEL_SUB = 1'b1;
  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;

endpackage

// File: rtl/gcd_controller_if.sv
// Handshake, comparator status and datapath control bundle of the GCD controller.
// The slave modport is the controller; the master modport is the host plus datapath.
interface gcd_controller_if;

  logic start;
  logic in_valid;
  logic in_ready;
  logic lt;
  logic gt;
  logic eq;
  logic ld_a;
  logic ld_b;
  logic sel_in;
  logic sel1;
  logic sel2;
  logic busy;
  logic done;
  logic err;
  logic done_ack;

  modport slave (
    input  start, in_valid, lt, gt, eq, done_ack,
    output in_ready, ld_a, ld_b, sel_in, sel1, sel2, busy, done, err
  );

  modport master (
    output start, in_valid, lt, gt, eq, done_ack,
    input  in_ready, ld_a, ld_b, sel_in, sel1, sel2, busy, done, err
  );

endinterface

// File: rtl/gcd_iter_counter.sv
// Per-job subtract counter with terminal-count flag against MAX_ITER.
// Saturates at MAX_ITER so it can never wrap even if the caller keeps incrementing.
module gcd_iter_counter #(
  parameter int MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtractive GCD datapath: operand intake, subtract loop,
// and done/error reporting. Status outputs are Moore; loads and selects are Mealy.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = 65535
) (
  input logic             clk,
  input logic             rst_n,
  gcd_controller_if.slave ctrl_if
);

  state_e state_q;
  state_e state_d;

  logic cnt_clr;
  logic cnt_inc;
  logic cnt_tc;

  logic in_ready_o;
  logic ld_a_o;
  logic ld_b_o;
  logic sel_in_o;
  logic sel1_o;
  logic sel2_o;
  logic busy_o;
  logic done_o;
  logic err_o;

  gcd_iter_counter #(
    .MAX_ITER(MAX_ITER)
  ) u_iter_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(cnt_clr),
    .inc_i(cnt_inc),
    .tc_o (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    ld_a_o     = 1'b0;
    ld_b_o     = 1'b0;
    sel_in_o   = SEL_DIN;
    sel1_o     = SEL_A;
    sel2_o     = SEL_A;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_if.start) begin
          state_d = S_LOAD_A;
        end
      end

      S_LOAD_A: begin
        busy_o     = 1'b1;
        in_ready_o = 1'b1;
        sel_in_o   = SEL_DIN;
        ld_a_o     = ctrl_if.in_valid;
        if (ctrl_if.in_valid) begin
          state_d = S_LOAD_B;
        end
      end

      S_LOAD_B: begin
        busy_o     = 1'b1;
        in_ready_o = 1'b1;
        sel_in_o   = SEL_DIN;
        ld_b_o     = ctrl_if.in_valid;
        if (ctrl_if.in_valid) begin
          state_d = S_CHECK;
          cnt_clr = 1'b1;
        end
      end

      // eq wins over everything, and the limit check precedes any further subtract
      S_CHECK: begin
        busy_o = 1'b1;
        if (ctrl_if.eq) begin
          state_d = S_DONE;
        end else if (cnt_tc) begin
          state_d = S_ERR;
        end else if (ctrl_if.gt) begin
          ld_a_o   = 1'b1;
          sel_in_o = SEL_SUB;
          sel1_o   = SEL_A;
          sel2_o   = SEL_B;
          cnt_inc  = 1'b1;
        end else if (ctrl_if.lt) begin
          ld_b_o   = 1'b1;
          sel_in_o = SEL_SUB;
          sel1_o   = SEL_B;
          sel2_o   = SEL_A;
          cnt_inc  = 1'b1;
        end
      end

      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
        if (ctrl_if.done_ack) begin
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        busy_o = 1'b1;
        done_o = 1'b1;
        err_o  = 1'b1;
        if (ctrl_if.done_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ctrl_if.in_ready = in_ready_o;
  assign ctrl_if.ld_a     = ld_a_o;
  assign ctrl_if.ld_b     = ld_b_o;
  assign ctrl_if.sel_in   = sel_in_o;
  assign ctrl_if.sel1     = sel1_o;
  assign ctrl_if.sel2     = sel2_o;
  assign ctrl_if.busy     = busy_o;
  assign ctrl_if.done     = done_o;
  assign ctrl_if.err      = err_o;

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control-path FSM for the 16-bit subtractive GCD datapath (operand registers A/B, operand muxes, subtractor, comparator). It consumes the comparator status (lt/gt/eq) and drives register loads and mux selects. It sequences operand intake over a valid/ready handshake, runs the subtract loop, and reports completion or an iteration-limit error to the host. The result is read by the host from datapath register A while `done` is high.

## Interface
- `MAX_ITER`, 65535: maximum subtract cycles per job before declaring error (≥1).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: host request; sampled only in IDLE.
- `in_valid` input 1: host has operand on the datapath `data_in` bus.
- `in_ready` output 1: controller accepts operand this cycle.
- `lt`, `gt`, `eq` inputs 1 each: comparator status, A vs B.
- `ld_a`, `ld_b` outputs 1 each: load enables for registers A and B.
- `sel_in` output 1: 0 = register input from `data_in`, 1 = from subtractor.
- `sel1` output 1: subtractor in1; 0 = A, 1 = B.
- `sel2` output 1: subtractor in2; 0 = A, 1 = B.
- `busy` output 1: job in progress (any state but IDLE).
- `done` output 1: result valid in A (or error flagged).
- `err` output 1: qualifies `done`; iteration limit hit.
- `done_ack` input 1: host has consumed the result.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CHECK, DONE, ERR.
- IDLE: `start`=1 → LOAD_A. `start` is ignored in all other states.
- LOAD_A: `in_ready`=1, `sel_in`=0, `ld_a`=`in_valid`. On `in_valid` → LOAD_B. Otherwise stay.
- LOAD_B: same as LOAD_A, driving `ld_b`. On `in_valid` → CHECK, and the iteration counter clears to 0.
- CHECK (one compare+subtract per cycle), in priority order:
  - `eq` → DONE, no load.
  - counter == `MAX_ITER` → ERR, no load.
  - `gt` → `ld_a`=1, `sel_in`=1, `sel1`=0, `sel2`=1 (A ← A−B), counter+1, stay.
  - `lt` → `ld_b`=1, `sel_in`=1, `sel1`=1, `sel2`=0 (B ← B−A), counter+1, stay.
- DONE: `done`=1, `err`=0. `done_ack` → IDLE.
- ERR: `done`=1, `err`=1. `done_ack` → IDLE.
- Output decoding:
  - `busy`, `done`, `err`, `in_ready` decode from state only (Moore).
  - `ld_a`, `ld_b`, `sel*` decode from state plus inputs (Mealy).
  - Default value of every control output is 0.
- Counter: width ceil(log2(MAX_ITER+1)); it never wraps, because ERR is taken at equality.
- A zero operand with a nonzero other never reaches `eq` and must terminate via ERR. 0,0 gives `eq` → DONE with result 0.
- Invalid status combinations (none or multiple of lt/gt/eq set) in CHECK: `eq` takes priority, then `gt`.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0. All outputs are 0 during and after reset.
- Reset mid-job: immediate return to IDLE. The datapath registers are not cleared by this block.
- Best-case latency, with `in_valid` held high and `start` seen in cycle 0:
  - LOAD_A in cycle 1; A captured at the end of cycle 1.
  - LOAD_B in cycle 2.
  - CHECK in cycle 3.
  - Equal operands: `done` in cycle 4.
- Each subtraction adds exactly 1 cycle.
- `done`/`err` stay high until `done_ack`. The state returns to IDLE the cycle after `done_ack`.
- A `start` asserted in the same cycle as `done_ack` is ignored. The host must reassert it in IDLE.

## Structure
- `gcd_pkg`:
  - State enum.
  - Mux select constants: SEL_DIN/SEL_SUB, SEL_A/SEL_B.
  - Data width constant (16).
- One sub-module, `gcd_iter_counter`: clear, increment, and terminal-count compare against `MAX_ITER`.
- Everything else lives in a single FSM module: state register plus combinational next-state/output logic.

## Test plan
- Reset mid-CHECK (assert `rst_n`=0 at cycle 5) → outputs 0 immediately, IDLE after release, next `start` runs cleanly.
- A=12, B=8, `in_valid` held high → one `gt` step then one `lt` step, `done` at cycle 6, A=4, `err`=0.
- A=9, B=9 → no loads in CHECK, `done` at cycle 4, result 9.
- `in_valid` low for 3 cycles in LOAD_A and 2 cycles in LOAD_B → `in_ready` high throughout those cycles, no loads until valid, results unchanged otherwise.
- `MAX_ITER`=4, A=0, B=5 → 4 `ld_b` pulses, then `done`=1 with `err`=1, held until `done_ack`.
- `start` pulsed during CHECK and in the same cycle as `done_ack` → both ignored; exactly one job per `start` accepted in IDLE.
